// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI shift engine and its clock divider.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } spi_state_t;

  localparam int SPI_DATA_BITS = 8;
  localparam int SPI_EDGES     = 16;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK edge-tick generator: one-cycle tick every div+1 clk cycles while enabled.
module spi_clk_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= 8'd0;
    end else if (cnt == div) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == div);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one byte per transfer, CPOL/CPHA/divider shadowed at start.
module spi_shift_engine
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] clk_div,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [4:0] LAST_EDGE = 5'(SPI_EDGES);

  spi_state_t                 state;
  logic                       cpol_s;
  logic                       cpha_s;
  logic [7:0]                 div_s;
  logic [SPI_DATA_BITS-1:0]   tx_shift;
  logic [SPI_DATA_BITS-1:0]   rx_shift;
  logic [4:0]                 edge_cnt;
  logic [4:0]                 edge_nxt;
  logic                       leading;
  logic                       sample;
  logic                       tick;

  assign busy     = (state != IDLE);
  assign edge_nxt = edge_cnt + 5'd1;
  // Odd edge numbers move SCLK away from its idle level.
  assign leading  = edge_nxt[0];
  assign sample   = (leading != cpha_s);

  spi_clk_div u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .div  (div_s),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cpol_s   <= 1'b0;
      cpha_s   <= 1'b0;
      div_s    <= 8'd0;
      tx_shift <= '0;
      rx_shift <= '0;
      edge_cnt <= 5'd0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (tx_start) begin
            cpol_s   <= cpol;
            cpha_s   <= cpha;
            div_s    <= clk_div;
            tx_shift <= tx_data;
            mosi     <= tx_data[SPI_DATA_BITS-1];
            edge_cnt <= 5'd0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick && edge_cnt != LAST_EDGE) begin
            edge_cnt <= edge_nxt;
            sclk     <= leading ? ~cpol_s : cpol_s;
            if (sample) begin
              rx_shift <= {rx_shift[SPI_DATA_BITS-2:0], miso};
            end else if (cpha_s) begin
              // CPHA=1 presents the current MSB on the leading edge, then advances.
              mosi     <= tx_shift[SPI_DATA_BITS-1];
              tx_shift <= tx_shift << 1;
            end else if (edge_nxt != LAST_EDGE) begin
              mosi     <= tx_shift[SPI_DATA_BITS-2];
              tx_shift <= tx_shift << 1;
            end
            if (edge_nxt == LAST_EDGE) begin
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          sclk <= cpol_s;
          if (tick) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: directed transfers checked by a bus monitor.
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol;
  logic       cpha;
  logic [7:0] clk_div;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       loop_en;
  logic       model_bit;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    logic       cpol;
    logic       cpha;
    int         hp;
    logic [7:0] pat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rxv_count = 0;

  assign miso = loop_en ? mosi : model_bit;

  always #5 clk = ~clk;

  spi_shift_engine dut (
    .clk      (clk),
    .rst      (rst),
    .cpol     (cpol),
    .cpha     (cpha),
    .clk_div  (clk_div),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bus monitor: measures each transfer on the pins and compares against the queue head.
  initial begin
    logic       prev;
    int         edges, last, gmin, gmax, bcnt, midx;
    logic [7:0] mb;
    exp_t       e;
    prev = 1'b0; edges = 0; last = 0; gmin = 9999; gmax = 0; bcnt = 0; midx = 7; mb = 8'h00;
    model_bit = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        edges = 0; gmin = 9999; gmax = 0; bcnt = 0; midx = 7; mb = 8'h00;
      end else if (rx_valid) begin
        rxv_count++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx_valid actual rx_data=%0h required no pulse", rx_data);
        end else begin
          e = q.pop_front();
          chk("rx_data", rx_data, e.rx);
          chk("mosi_byte", mb, e.tx);
          chk("edge_count", edges, 16);
          chk("half_period_min", gmin, e.hp);
          chk("half_period_max", gmax, e.hp);
          chk("busy_cycles", bcnt, 17 * e.hp);
        end
        edges = 0; gmin = 9999; gmax = 0; bcnt = 0; midx = 7; mb = 8'h00;
      end else begin
        if (busy) bcnt++;
        if (busy && sclk != prev && q.size() > 0) begin
          edges++;
          if (edges > 1) begin
            if (cyc - last < gmin) gmin = cyc - last;
            if (cyc - last > gmax) gmax = cyc - last;
          end
          last = cyc;
          if (sclk == (q[0].cpha ? q[0].cpol : ~q[0].cpol)) mb = {mb[6:0], mosi};
          if (sclk != q[0].cpol && midx >= 0) begin
            model_bit = q[0].pat[midx];
            midx--;
          end
        end
      end
      prev = sclk;
    end
  end

  task automatic start(input logic [7:0] d, input logic p, input logic h, input logic [7:0] div,
                       input logic lp, input logic [7:0] exp_rx, input logic [7:0] pat,
                       input logic push);
    exp_t e;
    tx_data = d; cpol = p; cpha = h; clk_div = div; loop_en = lp;
    e.rx = exp_rx; e.tx = d; e.cpol = p; e.cpha = h; e.hp = int'(div) + 1; e.pat = pat;
    if (push) q.push_back(e);
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual pending=%0d required 0", name, q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int  base;
    int  n;
    logic p;
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; tx_data = 8'h00;
    tx_start = 1'b0; loop_en = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Mode 0 loopback at full rate.
    start(8'hA5, 1'b0, 1'b0, 8'd0, 1'b1, 8'hA5, 8'h00, 1'b1);
    wait_done(100, "mode0");
    repeat (20) @(posedge clk); #1;
    chk("rx_hold", rx_data, 8'hA5);

    // Mode 3 with a slave model returning C3.
    cpol = 1'b1; cpha = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("idle_sclk_cpol1", sclk, 1);
    start(8'h3C, 1'b1, 1'b1, 8'd3, 1'b0, 8'hC3, 8'hC3, 1'b1);
    wait_done(300, "mode3");
    cpol = 1'b0; cpha = 1'b0; loop_en = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Shadowing: live settings change and a stray start mid-transfer.
    base = rxv_count;
    start(8'h5A, 1'b0, 1'b0, 8'd1, 1'b1, 8'h5A, 8'h00, 1'b1);
    repeat (6) @(posedge clk); #1;
    clk_div = 8'd7; tx_data = 8'h00; cpha = 1'b1; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0; cpha = 1'b0;
    wait_done(200, "shadow");
    repeat (40) @(posedge clk); #1;
    chk("one_rx_valid", rxv_count - base, 1);

    // Back-to-back: restart in the rx_valid cycle.
    start(8'h01, 1'b0, 1'b0, 8'd0, 1'b1, 8'h01, 8'h00, 1'b1);
    n = 0;
    while (!rx_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_rx_valid_seen", rx_valid, 1);
    start(8'hFF, 1'b0, 1'b0, 8'd0, 1'b1, 8'hFF, 8'h00, 1'b1);
    chk("b2b_no_gap", busy, 1);
    wait_done(100, "b2b");

    // Reset after edge 5 of an unqueued transfer.
    base = rxv_count;
    start(8'h96, 1'b0, 1'b0, 8'd1, 1'b1, 8'h96, 8'h00, 1'b0);
    n = 0; base = rxv_count;
    p = sclk;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(posedge clk); #1;
      if (sclk != p) n++;
      p = sclk;
    end
    chk("abort_edges_seen", n, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_sclk", sclk, 0);
    chk("abort_rx_data", rx_data, 8'h00);
    chk("abort_rx_valid", rx_valid, 0);
    chk("abort_mosi", mosi, 0);
    rst = 1'b0;
    repeat (40) @(posedge clk); #1;
    chk("abort_no_pulse", rxv_count - base, 0);
    cpol = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("post_reset_sclk_cpol", sclk, 1);

    // Fresh mode 2 transfer after the abort.
    start(8'h69, 1'b1, 1'b0, 8'd2, 1'b1, 8'h69, 8'h00, 1'b1);
    wait_done(200, "mode2");
    chk("final_rx_data", rx_data, 8'h69);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cpol  input  1  SCLK idle level, from the CR register.
REQ-005 cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge, from the CR register.
REQ-006 clk_div  input  8  SCLK half-period minus 1, in clk cycles, from the CDR register.
REQ-007 tx_data  input  8  byte to transmit, from the TDR register.
REQ-008 tx_start  input  1  single-cycle start request, raised on a TDR write.
REQ-009 busy  output  1  transfer active; drives SR.txact.
REQ-010 rx_data  output  8  last received byte; feeds the RDR register.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data updates; sets SR.rxne.
REQ-012 sclk  output  1  registered SPI clock.
REQ-013 mosi  output  1  registered serial data out, MSB first.
REQ-014 miso  input  1  serial data in, already synchronised externally.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and TAIL.
REQ-016 IDLE behaviour: busy=0; sclk SHALL follow cpol, registered.
REQ-017 IDLE with tx_start=1 (cycle 0):
- latch tx_data, cpol, cpha and clk_div into shadow registers;
- clear the edge counter and the divider;
- enter SHIFT, with busy=1 from cycle 1.
REQ-018 Changes to cpol, cpha, clk_div or tx_data while busy=1 SHALL have no effect on the current transfer.
REQ-019 tx_start while busy=1 SHALL be ignored, with no queuing.
REQ-020 Edge timing:
- define D = shadow clk_div;
- an edge tick SHALL occur every D+1 cycles;
- edge k (k = 1..16) SHALL be visible on sclk at cycle 1+k(D+1);
- D=0 gives SCLK = clk/2;
- D=255 gives a 256-cycle half-period.
REQ-021 Odd-numbered edges SHALL be leading edges (away from cpol); even-numbered edges SHALL be trailing edges.
REQ-022 CPHA=0:
- mosi = bit7 from cycle 1;
- sample miso on each leading edge;
- shift the next bit out on each trailing edge, except edge 16.
REQ-023 CPHA=1:
- mosi SHALL hold bit7 from cycle 1;
- shift bit n out on each leading edge, starting with bit7 on edge 1;
- sample miso on each trailing edge.
REQ-024 "Sample on edge k" SHALL mean capturing miso in the same clk cycle in which the sclk register takes its new value for edge k.
REQ-025 Received bits SHALL shift in MSB first; after 8 samples the shift register SHALL hold the received byte.
REQ-026 After edge 16 the FSM SHALL enter TAIL for D+1 cycles with sclk = cpol.
REQ-027 At cycle 1+17(D+1):
- busy=0;
- rx_data updated;
- rx_valid=1 for exactly one cycle;
- the FSM returns to IDLE.
REQ-028 tx_start SHALL be accepted in the cycle busy returns to 0, giving back-to-back transfers with no extra gap.
REQ-029 rx_data SHALL hold its value until the next completed transfer.
REQ-030 The divider and edge counter SHALL be unsigned; the edge counter SHALL be 5 bits wide and SHALL saturate/stop at 16, never wrapping.

Reset
REQ-031 On rst=1 the block SHALL abort any transfer and return to IDLE at the next clock, with:
- busy=0, rx_valid=0;
- rx_data=8'h00;
- sclk=0, mosi=0;
- shadow registers and counters = 0.
REQ-032 rx_valid SHALL NOT pulse for a transfer aborted by reset.
REQ-033 From the first cycle after rst deasserts, sclk SHALL follow cpol.

Structure
REQ-034 Shared package spi_pkg:
- spi_state_t enum (IDLE, SHIFT, TAIL);
- constant SPI_DATA_BITS = 8;
- constant SPI_EDGES = 16.
REQ-035 A single sub-module spi_clk_div SHALL be the only sub-module:
- inputs: clk, rst, en, div[7:0];
- output: one-cycle tick every div+1 cycles while en=1;
- counter cleared when en=0.

Verification
REQ-036 Mode 0, loopback:
- stimulus: cpol=0, cpha=0, clk_div=0, tx_data=8'hA5, miso tied to mosi, tx_start;
- response: 16 sclk edges, busy high for 17×1 cycles, rx_valid at cycle 18, rx_data=8'hA5.
REQ-037 Mode 3, fixed miso:
- stimulus: cpol=1, cpha=1, clk_div=3, tx_data=8'h3C, miso driven by a model returning 8'hC3;
- response: sclk idles high, each half-period is 4 cycles, mosi bits follow 0011_1100, rx_data=8'hC3.
REQ-038 Shadowing and ignored start:
- stimulus: start with clk_div=1, then change clk_div to 7 and pulse tx_start mid-transfer;
- response: half-period stays 2 cycles, exactly one rx_valid.
REQ-039 Back-to-back transfers:
- stimulus: assert tx_start in the rx_valid cycle with tx_data 8'h01, then 8'hFF;
- response: the second transfer starts with no idle gap, and both bytes appear on mosi.
REQ-040 Reset mid-transfer:
- stimulus: rst=1 after edge 5;
- response: next cycle busy=0, sclk=0, rx_data=8'h00, no rx_valid pulse, and a fresh transfer afterwards completes correctly.
